ddr3_ui_burst_sequencer: RTL

//  Sits upstream of the DDR3 async FIFO bridge in the ui_app_clk (fabric) domain. Takes burst requests
//  (addr, length, read/write) plus a write-data stream from the user design and expands them into
//  per-beat ui_cmd/ui_addr/ui_wr_en traffic under ui_cmd_ack backpressure. Meters outstanding reads with
//  a beat-credit counter so the RX FIFO never overflows, and tags returned read beats with rd_last.

---
 rtl/ddr3_ui_pkg.sv | 18 +
 rtl/ddr3_rd_len_fifo.sv | 54 +++++
 rtl/ddr3_ui_burst_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ddr3_ui_pkg.sv
// Shared types and constants for the DDR3 user-interface burst path.
package ddr3_ui_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR0,
    WR1,
    RD
  } seq_state_e;

  localparam int unsigned UI_DATA_W = 288;
  localparam int unsigned UI_MASK_W = 36;
  localparam int unsigned UI_ADDR_W = 32;

  localparam logic CMD_RD = 1'b1;
  localparam logic CMD_WR = 1'b0;

endpackage

// File: rtl/ddr3_rd_len_fifo.sv
// Small synchronous FIFO holding the beat count of each outstanding read burst.
module ddr3_rd_len_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ddr3_ui_burst_sequencer.sv
// Expands burst requests into per-beat UI traffic, meters read credits and
// tags the last returned beat of each read burst.
module ddr3_ui_burst_sequencer
  import ddr3_ui_pkg::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned RD_CREDITS = 512,
  parameter int unsigned RD_BURSTS  = 4
) (
  input  logic                 ui_app_clk,
  input  logic                 ui_rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rnw,
  input  logic [UI_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [UI_DATA_W-1:0] wr_data,
  input  logic [UI_MASK_W-1:0] wr_mask,
  output logic [UI_ADDR_W-1:0] ui_addr,
  output logic                 ui_cmd,
  output logic [UI_DATA_W-1:0] ui_wr_data,
  output logic [UI_MASK_W-1:0] ui_wr_mask,
  output logic                 ui_wr_en,
  input  logic                 ui_cmd_ack,
  input  logic                 ui_rd_valid,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 err_rd_unexp
);

  localparam int unsigned CRED_W = $clog2(RD_CREDITS + 1);
  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RD_CREDITS);

  seq_state_e           state;
  logic [UI_ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]     rem;
  logic [CRED_W-1:0]    credits;
  logic [CNT_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]     q_head;
  logic                 q_full;
  logic                 q_empty;
  logic                 q_push;
  logic                 req_fire;
  logic                 wr_issue;
  logic                 rd_issue;
  logic                 ret_ok;

  always_comb begin
    req_ready = (state == IDLE) && (!req_rnw || !q_full);
    wr_ready  = ((state == WR0) || (state == WR1)) && ui_cmd_ack;
    req_fire  = req_valid && req_ready;
    wr_issue  = wr_ready && wr_valid;
    rd_issue  = (state == RD) && ui_cmd_ack && (credits >= CRED_W'(2));
    q_push    = req_fire && req_rnw && (req_len != '0);
    ret_ok    = ui_rd_valid && !q_empty;
    rd_last   = ret_ok && (beat_cnt == q_head - CNT_W'(1));
    rd_valid  = ui_rd_valid;
    busy      = (state != IDLE) || (credits != CRED_MAX);
  end

  ddr3_rd_len_fifo #(
    .DEPTH(RD_BURSTS),
    .WIDTH(CNT_W)
  ) u_len_fifo (
    .clk  (ui_app_clk),
    .rst  (ui_rst),
    .push (q_push),
    .pop  (rd_last),
    .din  ({req_len, 1'b0}),
    .dout (q_head),
    .full (q_full),
    .empty(q_empty)
  );

  // Both beats of a write pair share one address; it only advances after WR1.
  always_ff @(posedge ui_app_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      rem        <= '0;
      ui_wr_en   <= 1'b0;
      ui_cmd     <= CMD_WR;
      ui_addr    <= '0;
      ui_wr_data <= '0;
      ui_wr_mask <= '0;
    end else begin
      ui_wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            cur_addr <= req_addr;
            rem      <= req_len;
            if (req_len != '0) state <= req_rnw ? RD : WR0;
          end
        end
        WR0, WR1: begin
          if (wr_issue) begin
            ui_wr_en   <= 1'b1;
            ui_cmd     <= CMD_WR;
            ui_addr    <= cur_addr;
            ui_wr_data <= wr_data;
            ui_wr_mask <= wr_mask;
            if (state == WR0) begin
              state <= WR1;
            end else begin
              cur_addr <= cur_addr + UI_ADDR_W'(1);
              rem      <= rem - LEN_W'(1);
              state    <= (rem == LEN_W'(1)) ? IDLE : WR0;
            end
          end
        end
        RD: begin
          if (rd_issue) begin
            ui_wr_en <= 1'b1;
            ui_cmd   <= CMD_RD;
            ui_addr  <= cur_addr;
            cur_addr <= cur_addr + UI_ADDR_W'(1);
            rem      <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A return seen with nothing outstanding is flagged and never adds a credit.
  always_ff @(posedge ui_app_clk or posedge ui_rst) begin
    if (ui_rst) begin
      credits      <= CRED_MAX;
      beat_cnt     <= '0;
      err_rd_unexp <= 1'b0;
    end else begin
      credits <= credits - (rd_issue ? CRED_W'(2) : '0)
                         + ((ui_rd_valid && (credits != CRED_MAX)) ? CRED_W'(1) : '0);
      if (ret_ok) beat_cnt <= rd_last ? '0 : beat_cnt + CNT_W'(1);
      if (ui_rd_valid && (q_empty || (credits == CRED_MAX))) err_rd_unexp <= 1'b1;
    end
  end

endmodule
